// File: rtl/montre_sysid_reader.sv
// ============================================================================
// Module  : montre_sysid_reader
// Brief   : Avalon-MM master that reads the sysid ID and timestamp words and
//           compares them with the expected build values.
//           Optional read timeout: define MONTRE_SYSID_READER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module montre_sysid_reader #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1665659394,
    parameter int          TIMEOUT_CYCLES     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ID   = 3'd1,
        S_WAIT_ID = 3'd2,
        S_RD_TS   = 3'd3,
        S_WAIT_TS = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_in_read;
    logic        w_in_wait;
    logic        w_progress;
    logic        w_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_id_match;
    logic        r_ts_match;

    assign w_in_read  = (r_state == S_RD_ID)   || (r_state == S_RD_TS);
    assign w_in_wait  = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
    // A response arriving on the accept cycle itself is not progress here.
    assign w_progress = (w_in_read && !avm_waitrequest) ||
                        (w_in_wait && avm_readdatavalid);

`ifdef MONTRE_SYSID_READER_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_timeout_err;

    assign w_timeout   = (w_in_read || w_in_wait) && (r_cnt >= c_TIMEOUT_LAST);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((w_next == S_RD_ID && r_state != S_RD_ID) ||
                (w_next == S_RD_TS && r_state != S_RD_TS)) begin
                r_cnt <= 8'd0;
            end else if ((w_in_read || w_in_wait) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_IDLE && start) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout && !w_progress) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_RD_ID;
            S_RD_ID:   if (w_progress) w_next = S_WAIT_ID;
                       else if (w_timeout) w_next = S_FIN;
            S_WAIT_ID: if (w_progress) w_next = S_RD_TS;
                       else if (w_timeout) w_next = S_FIN;
            S_RD_TS:   if (w_progress) w_next = S_WAIT_TS;
                       else if (w_timeout) w_next = S_FIN;
            S_WAIT_TS: if (w_progress) w_next = S_FIN;
                       else if (w_timeout) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Match flags are resolved on the final capture edge so they are valid with done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_id_match <= 1'b0;
                r_ts_match <= 1'b0;
            end
            if (r_state == S_WAIT_ID && avm_readdatavalid) begin
                r_id_value <= avm_readdata;
            end
            if (r_state == S_WAIT_TS && avm_readdatavalid) begin
                r_ts_value <= avm_readdata;
                r_ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
                r_id_match <= (r_id_value == EXPECTED_ID);
            end
        end
    end

    assign avm_read    = w_in_read;
    assign avm_address = (r_state == S_RD_TS);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign id_match    = r_id_match;
    assign ts_match    = r_ts_match;

endmodule

`default_nettype wire

// File: tb/tb_montre_sysid_reader.sv
// Testbench for montre_sysid_reader: table vectors, randomized transactions
// against an arithmetic latency/value model, plus reset and timeout sequences.
`default_nettype none

module tb_montre_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1665659394;

    logic        clock = 1'b0;
    logic        reset, start, waitreq, valid;
    logic [31:0] rdata;
    logic        avm_address, avm_read, busy, done, id_match, ts_match, timeout_err;
    logic [31:0] id_value, ts_value;

    montre_sysid_reader #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(waitreq), .avm_readdatavalid(valid), .avm_readdata(rdata),
        .busy(busy), .done(done), .id_value(id_value), .ts_value(ts_value),
        .id_match(id_match), .ts_match(ts_match), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          w0, d0;
        logic [31:0] v0;
        int          w1, d1;
        logic [31:0] v1;
        bit          junk, restart;
        bit          e_idm, e_tsm;
    } vec_t;

    // Slave stalls w cycles, then returns data d cycles after acceptance.
    // Expected done cycle follows from the FSM path: one cycle each in RD/WAIT
    // plus stalls and response delays, with start sampled at cycle 0.
    task automatic run_seq(input vec_t v);
        int          w[2], d[2];
        logic [31:0] val[2];
        int          rd_cyc[2];
        int          exp_done, stall, vcnt, cur, ndone, done_at;
        bit          pend, got_id, busy_ok, addr_ok, m_id, m_ts;
        w = '{v.w0, v.w1}; d = '{v.d0, v.d1}; val = '{v.v0, v.v1};
        rd_cyc = '{0, 0};
        exp_done = 3 + v.w0 + v.d0 + v.w1 + v.d1;
        stall = 0; vcnt = 0; cur = 0; ndone = 0; done_at = -1;
        pend = 0; got_id = 0; busy_ok = 1; addr_ok = 1; m_id = 0; m_ts = 0;
        for (int c = 0; c <= exp_done + 4; c++) begin
            @(negedge clock);
            if (busy !== (c >= 1 && c <= exp_done)) busy_ok = 0;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c; m_id = id_match; m_ts = ts_match;
                end
            end
            start   = (c == 0) || (v.restart && (c == 2 || c == 5));
            valid   = 1'b0;
            rdata   = $urandom;
            waitreq = 1'($urandom_range(0, 1));
            if (avm_read === 1'b1) begin
                if (avm_address !== got_id) addr_ok = 0;
                cur = int'(got_id);
                rd_cyc[cur]++;
                if (stall < w[cur]) begin
                    waitreq = 1'b1; stall++;
                end else begin
                    waitreq = 1'b0; stall = 0; pend = 1; vcnt = d[cur];
                    if (v.junk) valid = 1'b1;
                end
            end
            if (pend) begin
                if (vcnt == 0) begin
                    valid = 1'b1; rdata = val[cur]; pend = 0;
                    if (cur == 0) got_id = 1;
                end else begin
                    vcnt--;
                end
            end
        end
        @(negedge clock);
        start = 1'b0; valid = 1'b0;
        chk("done_cycle", done_at, exp_done);
        chk("done_count", ndone, 1);
        chk("busy_profile", busy_ok, 1);
        chk("addr_order", addr_ok, 1);
        chk("rd_cycles_id", rd_cyc[0], v.w0 + 1);
        chk("rd_cycles_ts", rd_cyc[1], v.w1 + 1);
        chk("id_match_at_done", m_id, v.e_idm);
        chk("ts_match_at_done", m_ts, v.e_tsm);
        chk("id_value", id_value, v.v0);
        chk("ts_value", ts_value, v.v1);
        chk("id_match_held", id_match, v.e_idm);
        chk("ts_match_held", ts_match, v.e_tsm);
        chk("timeout_err", timeout_err, 1'b0);
    endtask

    vec_t tbl[6];
    vec_t r;

    initial begin
        tbl[0] = '{0, 1, EXP_ID,        0, 1, EXP_TS,        0, 0, 1, 1};
        tbl[1] = '{3, 1, EXP_ID,        0, 1, EXP_TS,        0, 0, 1, 1};
        tbl[2] = '{0, 1, 32'h1234_5678, 0, 1, EXP_TS,        0, 0, 0, 1};
        tbl[3] = '{0, 1, EXP_ID,        0, 1, EXP_TS,        0, 1, 1, 1};
        tbl[4] = '{1, 2, EXP_ID,        2, 3, 32'hDEAD_BEEF, 1, 0, 1, 0};
        tbl[5] = '{2, 1, 32'hCAFE_F00D, 0, 4, EXP_TS,        1, 1, 0, 1};

        reset = 1'b1; start = 1'b0; waitreq = 1'b0; valid = 1'b0; rdata = 32'd0;
        repeat (3) @(negedge clock);
        chk("rst_avm_read", avm_read, 1'b0);
        chk("rst_avm_address", avm_address, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
        chk("rst_id_match", id_match, 1'b0);
        chk("rst_ts_match", ts_match, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_seq(tbl[i]);

        for (int i = 0; i < 25; i++) begin
            r.w0 = $urandom_range(0, 4); r.d0 = $urandom_range(1, 4);
            r.w1 = $urandom_range(0, 4); r.d1 = $urandom_range(1, 4);
            r.v0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            r.v1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            r.junk = 1'($urandom_range(0, 1));
            r.restart = 1'($urandom_range(0, 1));
            r.e_idm = (r.v0 == EXP_ID);
            r.e_tsm = (r.v1 == EXP_TS);
            run_seq(r);
        end

        // Slave never answers: abort with timeout, or hang forever without it.
        run_seq(tbl[0]);
        begin
            int done_at;
            done_at = -1;
            @(negedge clock);
            start = 1'b1; waitreq = 1'b0; valid = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clock);
                start = 1'b0;
                if (done === 1'b1 && done_at < 0) begin
                    done_at = c;
                    chk("to_id_match", id_match, 1'b0);
                    chk("to_ts_match", ts_match, 1'b0);
                end
            end
`ifdef MONTRE_SYSID_READER_TIMEOUT_EN
            chk("to_done_cycle", done_at, 17);
            chk("to_timeout_err", timeout_err, 1'b1);
            chk("to_busy_after", busy, 1'b0);
`else
            chk("to_no_done", done_at, -1);
            chk("to_busy_stuck", busy, 1'b1);
            chk("to_read_low", avm_read, 1'b0);
`endif
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            chk("to_reset_idle", busy, 1'b0);
        end

        // Reset during WAIT_TS, then a late response must be dropped.
        @(negedge clock);
        start = 1'b1; waitreq = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        valid = 1'b1; rdata = EXP_ID;
        @(negedge clock);
        valid = 1'b0;
        @(negedge clock);
        chk("rs_in_wait_ts", {busy, avm_read, avm_address}, 3'b100);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rs_busy", busy, 1'b0);
        chk("rs_done", done, 1'b0);
        valid = 1'b1; rdata = EXP_TS;
        @(negedge clock);
        valid = 1'b0;
        chk("rs_late_done", done, 1'b0);
        chk("rs_late_busy", busy, 1'b0);
        chk("rs_ts_value", ts_value, 32'd0);
        chk("rs_id_value", id_value, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/montre_sysid_reader.md
MONTRE_SYSID_READER -- requirements
Module: montre_sysid_reader

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, the expected system ID word at word address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'd1665659394, the expected timestamp word at word address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the cycles allowed per read before abort; legal range 1..255.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a check sequence.
REQ-007 SHALL have port avm_address, output, 1, the Avalon-MM word address to the sysid slave.
REQ-008 SHALL have port avm_read, output, 1, the Avalon-MM read strobe.
REQ-009 SHALL have port avm_waitrequest, input, 1, slave stall; the read is accepted on the first cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL have port avm_readdatavalid, input, 1, qualifying avm_readdata.
REQ-011 SHALL have port avm_readdata, input, 32, the read response data.
REQ-012 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse at sequence end.
REQ-014 SHALL have port id_value / ts_value, output, 32 each, the captured ID and timestamp words.
REQ-015 SHALL have port id_match / ts_match, output, 1 each, the comparison results, valid from done onward.
REQ-016 SHALL have port timeout_err, output, 1, indicating the last sequence aborted on timeout.

Function
REQ-017 SHALL implement the FSM IDLE -> RD_ID -> WAIT_ID -> RD_TS -> WAIT_TS -> FIN -> IDLE.
REQ-018 In IDLE, start=1 SHALL move to RD_ID next cycle; busy=1 in every state except IDLE.
REQ-019 In RD_ID, avm_read=1 and avm_address=0 SHALL hold until avm_waitrequest=0, then go to WAIT_ID; address and read stable while stalled.
REQ-020 WAIT_ID: avm_read=0; on avm_readdatavalid=1 capture id_value and go RD_TS.
REQ-021 RD_TS/WAIT_TS SHALL behave as RD_ID/WAIT_ID with avm_address=1, capturing ts_value.
REQ-022 avm_readdatavalid in the same cycle the read is accepted SHALL be ignored; only the WAIT state captures data.
REQ-023 FIN SHALL last exactly one cycle: done=1, id_match=(id_value==EXPECTED_ID), ts_match=(ts_value==EXPECTED_TIMESTAMP), then IDLE.
REQ-024 Minimum latency with zero wait and one-cycle readdatavalid: start at cycle 0 -> done at cycle 5.
REQ-025 start asserted while busy=1 SHALL be ignored (no queueing); start in FIN cycle ignored.
REQ-026 Match flags, values and timeout_err SHALL hold until the next sequence begins; entering RD_ID clears id_match, ts_match, timeout_err.
REQ-027 A per-read counter SHALL reset on entering each RD state and count cycles in RD+WAIT.

Reset
REQ-028 reset=1 SHALL force IDLE from any state on the next edge, abandoning any outstanding read.
REQ-029 Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_value=0, ts_value=0, id_match=0, ts_match=0, timeout_err=0, counter=0.
REQ-030 A readdatavalid arriving after reset mid-sequence SHALL be ignored in IDLE.

Configuration
REQ-031 Macro MONTRE_SYSID_READER_TIMEOUT_EN defined: counter reaching TIMEOUT_CYCLES in any RD/WAIT state SHALL deassert avm_read, set timeout_err=1, force both match flags 0, and go FIN (done pulse).
REQ-032 Macro undefined: no counter logic; timeout_err SHALL be tied 0 and the FSM waits indefinitely.

Verification
REQ-033 Zero-wait slave returning 0 then 1665659394: start -> done at cycle 5, id_match=1, ts_match=1, timeout_err=0.
REQ-034 waitrequest high 3 cycles on address 0: avm_read/avm_address=0 held 4 cycles; done at cycle 8; values correct.
REQ-035 Slave returns 32'h1234_5678 for ID: id_value=32'h1234_5678, id_match=0, ts_match=1.
REQ-036 With TIMEOUT_EN, TIMEOUT_CYCLES=16, readdatavalid never asserted: done 16 cycles after RD_ID entry, timeout_err=1, matches 0; without the macro busy stays 1.
REQ-037 reset pulsed during WAIT_TS, late readdatavalid: next cycle busy=0, no done, ts_value=0.
REQ-038 start re-pulsed at cycles 2 and 5: exactly one done; second sequence starts only after IDLE.
